// File: rtl/uart_cfg_sequencer.sv
// Wishbone classic master that programs a 16550-style UART after reset or on request.
// Issues six single-byte register writes in a fixed order and reports busy/done/error.
`timescale 1ns/1ps

module uart_cfg_sequencer #(
  parameter logic [15:0] DIVISOR     = 16'd27,
  parameter logic [7:0]  LCR_VAL     = 8'h03,
  parameter logic [7:0]  FCR_VAL     = 8'hC7,
  parameter logic [7:0]  IER_VAL     = 8'h00,
  parameter logic [7:0]  ACK_TIMEOUT = 8'd255,
  parameter bit          AUTO_START  = 1'b1
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       cfg_start_i,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  output logic       wb_we_o,
  output logic [3:0] wb_sel_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  input  logic       wb_ack_i,
  output logic       cfg_busy_o,
  output logic       cfg_done_o,
  output logic       cfg_err_o
);

  typedef enum logic [2:0] {IDLE, REQ, GAP, DONE, ERR} state_t;

  localparam logic [2:0] LAST_STEP = 3'd5;
  localparam logic [7:0] CNT_LAST  = ACK_TIMEOUT - 8'd1;

  state_t     state, state_n;
  logic [2:0] step, step_n;
  logic [7:0] cnt, cnt_n;
  logic [2:0] adr, adr_n;
  logic [7:0] dat, dat_n;
  logic       stb, stb_n;
  logic       busy, busy_n;
  logic       done, done_n;
  logic       err, err_n;
  logic       first;
  logic       go;

  // DLAB is set for the divisor writes and cleared again before FCR/IER.
  function automatic logic [10:0] step_entry(input logic [2:0] s);
    logic [10:0] e;
    case (s)
      3'd0:    e = {3'd3, LCR_VAL | 8'h80};
      3'd1:    e = {3'd0, DIVISOR[7:0]};
      3'd2:    e = {3'd1, DIVISOR[15:8]};
      3'd3:    e = {3'd3, LCR_VAL & 8'h7F};
      3'd4:    e = {3'd2, FCR_VAL};
      3'd5:    e = {3'd1, IER_VAL};
      default: e = 11'd0;
    endcase
    return e;
  endfunction

  // Flags the first cycle after reset release so AUTO_START fires exactly once.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) first <= 1'b1;
    else          first <= 1'b0;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      step  <= 3'd0;
      cnt   <= 8'd0;
      adr   <= 3'd0;
      dat   <= 8'd0;
      stb   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      step  <= step_n;
      cnt   <= cnt_n;
      adr   <= adr_n;
      dat   <= dat_n;
      stb   <= stb_n;
      busy  <= busy_n;
      done  <= done_n;
      err   <= err_n;
    end
  end

  // Next-state logic computes next output values so every bus signal leaves a flop.
  always_comb begin
    state_n = state;
    step_n  = step;
    cnt_n   = cnt;
    adr_n   = adr;
    dat_n   = dat;
    stb_n   = stb;
    busy_n  = busy;
    done_n  = done;
    err_n   = err;
    go      = cfg_start_i | (AUTO_START & first);

    case (state)
      IDLE, DONE, ERR: begin
        if ((state == IDLE) ? go : cfg_start_i) begin
          state_n          = REQ;
          step_n           = 3'd0;
          cnt_n            = 8'd0;
          stb_n            = 1'b1;
          {adr_n, dat_n}   = step_entry(3'd0);
          busy_n           = 1'b1;
          done_n           = 1'b0;
          err_n            = 1'b0;
        end
      end
      REQ: begin
        if (wb_ack_i) begin
          stb_n = 1'b0;
          cnt_n = 8'd0;
          if (step < LAST_STEP) begin
            state_n = GAP;
          end else begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end else if (cnt == CNT_LAST) begin
          state_n = ERR;
          stb_n   = 1'b0;
          busy_n  = 1'b0;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      GAP: begin
        state_n        = REQ;
        step_n         = step + 3'd1;
        cnt_n          = 8'd0;
        stb_n          = 1'b1;
        {adr_n, dat_n} = step_entry(step + 3'd1);
      end
      default: state_n = IDLE;
    endcase
  end

  assign wb_adr_o   = adr;
  assign wb_dat_o   = dat;
  assign wb_stb_o   = stb;
  assign wb_cyc_o   = stb;
  assign wb_we_o    = stb;
  assign wb_sel_o   = 4'b0001;
  assign cfg_busy_o = busy;
  assign cfg_done_o = done;
  assign cfg_err_o  = err;

endmodule

// File: tb/tb_uart_cfg_sequencer.sv
// Self-checking bench for uart_cfg_sequencer: scripted Wishbone slave model with
// wait states / no-ack / spurious acks, and a scoreboard of expected register writes.
`timescale 1ns/1ps

module tb_uart_cfg_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] adr;
  logic [7:0] dat;
  logic       we;
  logic [3:0] sel;
  logic       stb;
  logic       cyc;
  logic       ack;
  logic       busy;
  logic       done;
  logic       err;

  int         checks = 0;
  int         errors = 0;
  int         ws = 0;
  logic       never = 1'b0;
  logic       spur = 1'b0;
  int         wait_cnt = 0;
  int         stb_len = 0;
  int         writes_seen = 0;
  logic       hold_prev = 1'b0;
  logic [2:0] prev_adr = 3'd0;
  logic [7:0] prev_dat = 8'd0;
  logic [10:0] exp_entry;
  logic [10:0] sb[$];

  uart_cfg_sequencer #(.ACK_TIMEOUT(8'd8)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .cfg_start_i(start),
    .wb_adr_o   (adr),
    .wb_dat_o   (dat),
    .wb_we_o    (we),
    .wb_sel_o   (sel),
    .wb_stb_o   (stb),
    .wb_cyc_o   (cyc),
    .wb_ack_i   (ack),
    .cfg_busy_o (busy),
    .cfg_done_o (done),
    .cfg_err_o  (err)
  );

  always #5 clk = ~clk;

  // Slave model: acks after ws wait states unless silenced; spur injects stray acks.
  assign ack = spur | (stb & ~never & (wait_cnt == ws));

  always @(posedge clk) begin
    if (stb && !ack) wait_cnt <= wait_cnt + 1;
    else             wait_cnt <= 0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pushSequence();
    sb.push_back({3'd3, 8'h83});
    sb.push_back({3'd0, 8'h1B});
    sb.push_back({3'd1, 8'h00});
    sb.push_back({3'd3, 8'h03});
    sb.push_back({3'd2, 8'hC7});
    sb.push_back({3'd1, 8'h00});
  endtask

  // Pulses start for one cycle; returns at the negedge where the first stb is visible.
  task automatic applyStimulus(input bit do_push);
    if (do_push) pushSequence();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int max_cycles, output int cycles);
    cycles = 0;
    while (!(done || err) && cycles < max_cycles) begin
      @(negedge clk);
      cycles++;
    end
    if (!(done || err)) checkOutput("wait_bound", 32'(done | err), 32'd1);
  endtask

  // Bus monitor: pops the scoreboard on each completed write and checks bus rules.
  always @(negedge clk) begin
    checkOutput("done_err_excl", 32'(done & err), 32'd0);
    checkOutput("cyc_eq_stb", 32'(cyc), 32'(stb));
    checkOutput("we_eq_stb", 32'(we), 32'(stb));
    if (stb) begin
      if (hold_prev) begin
        checkOutput("adr_stable", 32'(adr), 32'(prev_adr));
        checkOutput("dat_stable", 32'(dat), 32'(prev_dat));
      end
      stb_len++;
      if (ack) begin
        if (sb.size() == 0) begin
          checkOutput("sb_nonempty", 32'(sb.size()), 32'd1);
        end else begin
          exp_entry = sb.pop_front();
          checkOutput("wr_adr", 32'(adr), 32'(exp_entry[10:8]));
          checkOutput("wr_dat", 32'(dat), 32'(exp_entry[7:0]));
        end
        checkOutput("stb_len", 32'(stb_len), 32'(ws + 1));
        writes_seen++;
        stb_len   = 0;
        hold_prev = 1'b0;
      end else begin
        hold_prev = 1'b1;
        prev_adr  = adr;
        prev_dat  = dat;
      end
    end else begin
      stb_len   = 0;
      hold_prev = 1'b0;
    end
  end

  initial begin
    int cyc_cnt;
    int len;
    int w0;

    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_adr", 32'(adr), 32'd0);
    checkOutput("rst_dat", 32'(dat), 32'd0);
    checkOutput("rst_stb", 32'(stb), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("sel_const", 32'(sel), 32'd1);

    $display("[TB] auto start after reset release");
    pushSequence();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("auto_stb", 32'(stb), 32'd1);
    checkOutput("auto_busy", 32'(busy), 32'd1);
    waitDone(50, cyc_cnt);
    checkOutput("auto_done_lat", 32'(cyc_cnt), 32'd11);
    checkOutput("auto_done", 32'(done), 32'd1);
    checkOutput("auto_busy_end", 32'(busy), 32'd0);
    checkOutput("auto_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] start pulse while busy is ignored");
    applyStimulus(1'b1);
    checkOutput("restart_stb", 32'(stb), 32'd1);
    checkOutput("restart_done_clr", 32'(done), 32'd0);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(50, cyc_cnt);
    checkOutput("busy_start_lat", 32'(cyc_cnt), 32'd6);
    checkOutput("busy_start_sb", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("no_rerun_stb", 32'(stb), 32'd0);

    $display("[TB] three wait states per write");
    ws = 3;
    applyStimulus(1'b1);
    waitDone(100, cyc_cnt);
    checkOutput("ws_done_lat", 32'(cyc_cnt), 32'd29);
    checkOutput("ws_done", 32'(done), 32'd1);
    checkOutput("ws_err", 32'(err), 32'd0);
    checkOutput("ws_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] spurious acks in gaps and done");
    ws = 0;
    w0 = writes_seen;
    applyStimulus(1'b1);
    cyc_cnt = 0;
    while (!done && cyc_cnt < 50) begin
      spur = ~stb;
      @(negedge clk);
      cyc_cnt++;
    end
    checkOutput("spur_done_lat", 32'(cyc_cnt), 32'd11);
    spur = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("spur_done_stb", 32'(stb), 32'd0);
    spur = 1'b0;
    checkOutput("spur_writes", 32'(writes_seen - w0), 32'd6);
    checkOutput("spur_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] ack timeout");
    never = 1'b1;
    applyStimulus(1'b0);
    checkOutput("to_adr", 32'(adr), 32'd3);
    len = 0;
    while (stb && len < 40) begin
      len++;
      @(negedge clk);
    end
    checkOutput("to_stb_len", 32'(len), 32'd8);
    checkOutput("to_err", 32'(err), 32'd1);
    checkOutput("to_done", 32'(done), 32'd0);
    checkOutput("to_busy", 32'(busy), 32'd0);
    never = 1'b0;
    applyStimulus(1'b1);
    checkOutput("err_clr", 32'(err), 32'd0);
    checkOutput("err_restart_busy", 32'(busy), 32'd1);
    waitDone(50, cyc_cnt);
    checkOutput("err_restart_lat", 32'(cyc_cnt), 32'd11);
    checkOutput("err_restart_done", 32'(done), 32'd1);

    $display("[TB] reset during step 3");
    applyStimulus(1'b1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2;
    checkOutput("pre_rst_stb", 32'(stb), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("async_stb", 32'(stb), 32'd0);
    checkOutput("async_cyc", 32'(cyc), 32'd0);
    checkOutput("async_adr", 32'(adr), 32'd0);
    checkOutput("async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("rst_sb_left", 32'(sb.size()), 32'd3);
    sb.delete();
    pushSequence();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rerun_stb", 32'(stb), 32'd1);
    checkOutput("rerun_adr", 32'(adr), 32'd3);
    waitDone(50, cyc_cnt);
    checkOutput("rerun_lat", 32'(cyc_cnt), 32'd11);
    checkOutput("rerun_done", 32'(done), 32'd1);
    checkOutput("rerun_sb_empty", 32'(sb.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
